// File: rtl/cpu7_ifu_fdq.sv
// cpu7_ifu_fdq: fetch-to-decode queue.
// Buffers fetch responses (pc, instruction, fetch exception) in a small circular
// buffer and presents the oldest entry show-ahead to IFU decode. A taken branch
// resolved in E flushes every buffered entry. The response offered in the same
// cycle as the flush is also dropped.
module cpu7_ifu_fdq #(
    parameter int GRLEN = 32,
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inst_valid,
    input  logic [GRLEN-1:0] inst_pc,
    input  logic [31:0]      inst_rdata,
    input  logic             inst_exception,
    input  logic [5:0]       inst_exccode,
    output logic             fdq_inst_ready,
    input  logic             exu_ifu_stall_req,
    input  logic             exu_ifu_br_taken_e,
    output logic             fdq_dec_valid_d,
    output logic [GRLEN-1:0] fdq_dec_pc_d,
    output logic [31:0]      fdq_dec_inst_d,
    output logic             fdq_dec_exception_d,
    output logic [5:0]       fdq_dec_exccode_d,
    output logic [PTR_W:0]   fdq_count
);

    localparam logic [PTR_W:0]   COUNT_FULL = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   COUNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

    // One queue entry: everything decode needs about a fetched instruction.
    typedef struct packed {
        logic [GRLEN-1:0] pc;
        logic [31:0]      inst;
        logic             exception;
        logic [5:0]       exccode;
    } entry_t;

    entry_t           entry_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic             push;
    logic             pop;
    logic             flush;
    entry_t           head;

    // Handshake decode. Ready depends only on the registered count, so a full queue
    // refuses a new response even in a cycle where decode pops an entry.
    always_comb begin
        flush           = exu_ifu_br_taken_e;
        fdq_inst_ready  = (count_reg != COUNT_FULL);
        fdq_dec_valid_d = (count_reg != '0);
        push            = inst_valid & fdq_inst_ready & ~flush;
        pop             = fdq_dec_valid_d & ~exu_ifu_stall_req & ~flush;
    end

    // Pointer and occupancy state. Reset beats flush, and flush beats push and pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + COUNT_ONE;
                2'b01:   count_reg <= count_reg - COUNT_ONE;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Payload storage has no reset. A stale entry is never presented, because the
    // valid signal is derived from the count.
    always_ff @(posedge clk) begin
        if (push) begin
            entry_mem[wr_ptr_reg] <= '{pc: inst_pc, inst: inst_rdata,
                                       exception: inst_exception, exccode: inst_exccode};
        end
    end

    // Show-ahead head: the entry under rd_ptr drives the decode outputs directly.
    always_comb begin
        head                = entry_mem[rd_ptr_reg];
        fdq_dec_pc_d        = head.pc;
        fdq_dec_inst_d      = head.inst;
        fdq_dec_exception_d = head.exception;
        fdq_dec_exccode_d   = head.exccode;
        fdq_count           = count_reg;
    end

endmodule

// File: tb/tb_cpu7_ifu_fdq.sv
// Testbench for cpu7_ifu_fdq. It runs directed scenarios and then randomized traffic.
// The expected behaviour comes from a queue-based reference model.
module tb_cpu7_ifu_fdq;

    localparam int GRLEN = 32;
    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             inst_valid;
    logic [GRLEN-1:0] inst_pc;
    logic [31:0]      inst_rdata;
    logic             inst_exception;
    logic [5:0]       inst_exccode;
    logic             fdq_inst_ready;
    logic             exu_ifu_stall_req;
    logic             exu_ifu_br_taken_e;
    logic             fdq_dec_valid_d;
    logic [GRLEN-1:0] fdq_dec_pc_d;
    logic [31:0]      fdq_dec_inst_d;
    logic             fdq_dec_exception_d;
    logic [5:0]       fdq_dec_exccode_d;
    logic [PTR_W:0]   fdq_count;

    always #5 clk = ~clk;

    cpu7_ifu_fdq #(.GRLEN(GRLEN), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk                 (clk),
        .reset               (reset),
        .inst_valid          (inst_valid),
        .inst_pc             (inst_pc),
        .inst_rdata          (inst_rdata),
        .inst_exception      (inst_exception),
        .inst_exccode        (inst_exccode),
        .fdq_inst_ready      (fdq_inst_ready),
        .exu_ifu_stall_req   (exu_ifu_stall_req),
        .exu_ifu_br_taken_e  (exu_ifu_br_taken_e),
        .fdq_dec_valid_d     (fdq_dec_valid_d),
        .fdq_dec_pc_d        (fdq_dec_pc_d),
        .fdq_dec_inst_d      (fdq_dec_inst_d),
        .fdq_dec_exception_d (fdq_dec_exception_d),
        .fdq_dec_exccode_d   (fdq_dec_exccode_d),
        .fdq_count           (fdq_count)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        exc;
        logic [5:0]  code;
    } ent_t;

    ent_t model_q[$];
    bit   model_known = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Compare every visible output with the model state.
    task automatic check_outputs();
        if (model_known) begin
            chk("count", 64'(fdq_count), 64'(model_q.size()));
            chk("ready", 64'(fdq_inst_ready), 64'(model_q.size() != DEPTH));
            chk("valid", 64'(fdq_dec_valid_d), 64'(model_q.size() != 0));
            if (model_q.size() != 0) begin
                chk("head_pc", 64'(fdq_dec_pc_d), 64'(model_q[0].pc));
                chk("head_inst", 64'(fdq_dec_inst_d), 64'(model_q[0].inst));
                chk("head_exc", 64'(fdq_dec_exception_d), 64'(model_q[0].exc));
                chk("head_code", 64'(fdq_dec_exccode_d), 64'(model_q[0].code));
            end
        end
    endtask

    // One clock cycle. It checks the current outputs, drives the inputs, clocks the DUT and steps the model.
    task automatic cyc(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                       input logic exc, input logic [5:0] code,
                       input logic stall, input logic br, input logic rst);
        bit   full;
        bit   did_pop;
        bit   did_push;
        ent_t e;
        check_outputs();
        inst_valid         = v;
        inst_pc            = pc;
        inst_rdata         = inst;
        inst_exception     = exc;
        inst_exccode       = code;
        exu_ifu_stall_req  = stall;
        exu_ifu_br_taken_e = br;
        reset              = rst;
        @(posedge clk);
        did_pop  = 1'b0;
        did_push = 1'b0;
        if (rst) begin
            model_q.delete();
            model_known = 1'b1;
        end else if (model_known) begin
            if (br) begin
                model_q.delete();
            end else begin
                full = (model_q.size() == DEPTH);
                if (model_q.size() != 0 && !stall) begin
                    e = model_q.pop_front();
                    did_pop = 1'b1;
                end
                if (v && !full) begin
                    model_q.push_back('{pc: pc, inst: inst, exc: exc, code: code});
                    did_push = 1'b1;
                end
            end
        end
        if (rst || br || did_pop || did_push)
            $display("t=%0t rst=%0b flush=%0b push=%0b pc=%08h pop=%0b occ=%0d",
                     $time, rst, br, did_push, pc, did_pop, model_q.size());
        #1;
    endtask

    task automatic idle(input logic stall);
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 6'h0, stall, 1'b0, 1'b0);
    endtask

    task automatic push_one(input logic [31:0] pc, input logic stall);
        cyc(1'b1, pc, pc ^ 32'h5a5a_0000, 1'b0, 6'h0, stall, 1'b0, 1'b0);
    endtask

    initial begin
        // Scenario 1: reset, then one instruction flows through the queue.
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 6'h0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 6'h0, 1'b0, 1'b0, 1'b1);
        chk("rst_count", 64'(fdq_count), 64'd0);
        chk("rst_ready", 64'(fdq_inst_ready), 64'd1);
        cyc(1'b1, 32'h1c00_0000, 32'h0280_0401, 1'b0, 6'h0, 1'b0, 1'b0, 1'b0);
        chk("t1_valid", 64'(fdq_dec_valid_d), 64'd1);
        chk("t1_pc", 64'(fdq_dec_pc_d), 64'h1c00_0000);
        chk("t1_inst", 64'(fdq_dec_inst_d), 64'h0280_0401);
        idle(1'b0);
        chk("t1_empty", 64'(fdq_count), 64'd0);

        // Scenario 2: fill the queue while stalled; a fifth response is refused.
        for (int i = 0; i < 4; i++) push_one(32'h100 + 32'(4 * i), 1'b1);
        chk("t2_full", 64'(fdq_count), 64'd4);
        chk("t2_ready", 64'(fdq_inst_ready), 64'd0);
        push_one(32'h110, 1'b1);
        chk("t2_hold", 64'(fdq_count), 64'd4);
        idle(1'b0);
        chk("t2_ready_after_pop", 64'(fdq_inst_ready), 64'd1);
        for (int i = 0; i < 3; i++) idle(1'b0);
        chk("t2_drained", 64'(fdq_count), 64'd0);

        // Scenario 3: occupancy held at 2 by simultaneous push and pop across the pointer wrap.
        push_one(32'h300, 1'b0);
        push_one(32'h304, 1'b1);
        for (int i = 0; i < 6; i++) begin
            push_one(32'h308 + 32'(4 * i), 1'b0);
            chk("t3_count", 64'(fdq_count), 64'd2);
        end
        idle(1'b0);
        idle(1'b0);

        // Scenario 4: flush with three entries queued; the response in the flush cycle is dropped.
        for (int i = 0; i < 3; i++) push_one(32'h400 + 32'(4 * i), 1'b1);
        chk("t4_three", 64'(fdq_count), 64'd3);
        cyc(1'b1, 32'h999, 32'h999, 1'b0, 6'h0, 1'b1, 1'b1, 1'b0);
        chk("t4_flush_count", 64'(fdq_count), 64'd0);
        chk("t4_flush_valid", 64'(fdq_dec_valid_d), 64'd0);
        push_one(32'h200, 1'b0);
        chk("t4_new_pc", 64'(fdq_dec_pc_d), 64'h200);
        idle(1'b0);

        // Scenario 5: a fetch exception travels with its entry.
        cyc(1'b1, 32'h500, 32'h0, 1'b1, 6'h08, 1'b1, 1'b0, 1'b0);
        chk("t5_exc", 64'(fdq_dec_exception_d), 64'd1);
        chk("t5_code", 64'(fdq_dec_exccode_d), 64'h08);
        idle(1'b0);

        // Scenario 6: reset in the middle of operation with three entries queued.
        for (int i = 0; i < 3; i++) push_one(32'h600 + 32'(4 * i), 1'b1);
        cyc(1'b0, 32'h0, 32'h0, 1'b0, 6'h0, 1'b1, 1'b0, 1'b1);
        chk("t6_count", 64'(fdq_count), 64'd0);
        chk("t6_valid", 64'(fdq_dec_valid_d), 64'd0);
        chk("t6_ready", 64'(fdq_inst_ready), 64'd1);

        // Randomized traffic checked against the reference model.
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(99) < 70), $urandom(), $urandom(),
                ($urandom_range(9) == 0), 6'($urandom_range(63)),
                ($urandom_range(99) < 35), ($urandom_range(99) < 5),
                ($urandom_range(99) < 1));
        end
        check_outputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
